// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the store/load lane logic.
//   - SIZE_* : encodings of the 2-bit access size field (byte/half/word/illegal)
//   - store_state_e : state encoding of the store narrowing FSM
//   - size_mask() : per-byte enable mask of an access, before lane shifting
package riscv_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10,
        RESP  = 2'b11
    } store_state_e;

    // An illegal size yields an empty mask, so it can never produce bus traffic.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001;
            SIZE_HALF: mask = 4'b0011;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// store_lane_align
// Combinational lane alignment of a sized value within a two-word window.
// Ports:
//   off   [1:0]  : byte offset of the access within its word
//   size  [1:0]  : access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   wdata [31:0] : unaligned source value, only the low bytes of the size are used
//   be8   [7:0]  : byte enables across the two words (low nibble = first word)
//   d64   [63:0] : lane-aligned data across the two words, disabled lanes are 0
//   split        : access spills into the second word
module store_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [7:0]  be8,
    output logic [63:0] d64,
    output logic        split
);

    logic [3:0]  mask;
    logic [31:0] sized;

    // Clear the bytes above the access size so unused lanes stay zero after shifting.
    always_comb begin
        mask  = size_mask(size);
        sized = wdata & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    end

    assign be8   = {4'b0000, mask} << off;
    assign d64   = {32'h0000_0000, sized} << {off, 3'b000};
    assign split = |be8[7:4];

endmodule

// File: rtl/store_narrow_unit.sv
// store_narrow_unit
// Narrows a store from the execute stage onto a 32-bit data-memory write port,
// splitting word-boundary-crossing stores into two bus beats.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake (ready only in IDLE)
//   req_addr, req_wdata, req_size   : byte address, rs2 value, access size
//   mem_valid/mem_ready             : bus beat handshake
//   mem_addr, mem_wdata, mem_be     : word-aligned address, lane data, byte enables
//   done, err                       : one-cycle completion pulse and rejection flag
module store_narrow_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              err
);

    store_state_e      state;
    logic [7:0]        be8;
    logic [63:0]       d64;
    logic              split;
    logic              req_bad;
    logic [ADDR_W-1:0] word_addr;

    // Second-beat fields captured at accept time, replayed after beat 0 completes.
    logic [3:0]        hi_be;
    logic [31:0]       hi_data;
    logic              split_q;

    store_lane_align u_align (
        .off   (req_addr[1:0]),
        .size  (req_size),
        .wdata (req_wdata),
        .be8   (be8),
        .d64   (d64),
        .split (split)
    );

    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    assign req_bad   = (req_size == SIZE_ILLEGAL) || (split && !ALLOW_MISALIGNED);

    // All bus and response outputs are registered; the bus fields only change on
    // accept or on a beat handshake, which keeps them stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            hi_be     <= '0;
            hi_data   <= '0;
            split_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= word_addr;
                            mem_be    <= be8[3:0];
                            mem_wdata <= d64[31:0];
                            hi_be     <= be8[7:4];
                            hi_data   <= d64[63:32];
                            split_q   <= split;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (split_q) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + ADDR_W'(4);
                            mem_be    <= hi_be;
                            mem_wdata <= hi_data;
                        end else begin
                            state     <= RESP;
                            mem_valid <= 1'b0;
                            mem_addr  <= '0;
                            mem_be    <= '0;
                            mem_wdata <= '0;
                            done      <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        state     <= RESP;
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        done      <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit
// Self-checking bench for store_narrow_unit. A byte-by-byte model predicts the
// bus beats of each store; a negedge compare process checks every beat and
// completion against it. A second instance with misaligned stores disabled
// covers rejection of boundary-crossing stores.
module tb_store_narrow_unit;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    logic        na_req_valid;
    logic        na_req_ready;
    logic        na_mem_valid;
    logic [31:0] na_mem_addr;
    logic [31:0] na_mem_wdata;
    logic [3:0]  na_mem_be;
    logic        na_done;
    logic        na_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    beat_t       exp_q[$];
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    store_narrow_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err)
    );

    store_narrow_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (na_req_valid),
        .req_ready (na_req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .mem_valid (na_mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (na_mem_addr),
        .mem_wdata (na_mem_wdata),
        .mem_be    (na_mem_be),
        .done      (na_done),
        .err       (na_err)
    );

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: place each stored byte at its own byte address, then group bytes by
    // the word they land in. Pushes the expected beats and returns the first one.
    task automatic modelPush(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size, output bit is_err,
                             output int nbeats, output beat_t first);
        int          n;
        int          lane;
        logic [31:0] a;
        logic [7:0]  byte_v;
        beat_t       b0;
        beat_t       b1;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
        b0.addr = addr & 32'hFFFF_FFFC;
        b0.be   = 4'b0000;
        b0.data = 32'h0;
        b1.addr = b0.addr + 32'd4;
        b1.be   = 4'b0000;
        b1.data = 32'h0;
        for (int i = 0; i < n; i++) begin
            a      = addr + 32'(i);
            lane   = int'(a % 32'd4);
            byte_v = 8'(data >> (8 * i));
            if ((a & 32'hFFFF_FFFC) == b0.addr) begin
                b0.be[lane] = 1'b1;
                b0.data     = b0.data | (32'(byte_v) << (8 * lane));
            end else begin
                b1.be[lane] = 1'b1;
                b1.data     = b1.data | (32'(byte_v) << (8 * lane));
            end
        end
        is_err = (n == 0);
        nbeats = 0;
        first  = b0;
        if (!is_err) begin
            exp_q.push_back(b0);
            nbeats = 1;
            if (b1.be != 4'b0000) begin
                exp_q.push_back(b1);
                nbeats = 2;
            end
        end
    endtask

    // Compare process: every beat against the model, every completion against
    // the expected error flag with no beats outstanding.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got addr 0x%0h be %b, expected no beat", mem_addr, mem_be);
                end else begin
                    checkOutput("beat_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                    checkOutput("beat_be", 64'(mem_be), 64'(exp_q[0].be));
                    checkOutput("beat_wdata", 64'(mem_wdata), 64'(exp_q[0].data));
                    if (mem_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                checkOutput("done_err", 64'(err), 64'(exp_err));
                checkOutput("done_beats_left", 64'(exp_q.size()), 64'd0);
            end else begin
                checkOutput("err_without_done", 64'(err), 64'd0);
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        checkOutput({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        checkOutput({tag, "_mem_be"}, 64'(mem_be), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
    endtask

    task automatic waitReady();
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_ready_timeout: got 0, expected 1 within 20 cycles");
        end
    endtask

    // One store on the main instance. stall = cycles mem_ready is held low
    // after accept; exp_lat uses the N+k labelling (accept edge = N).
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size, input int stall, input int exp_lat,
                                 input bit pin_err, input logic [31:0] pin_addr,
                                 input logic [3:0] pin_be, input logic [31:0] pin_data);
        bit    m_err;
        int    nbeats;
        beat_t first;
        int    acc;
        int    k;
        bit    seen;
        waitReady();
        mem_ready = (stall == 0);
        req_addr  = addr;
        req_wdata = data;
        req_size  = size;
        modelPush(addr, data, size, m_err, nbeats, first);
        exp_err = m_err;
        checkOutput("model_err", 64'(m_err), 64'(pin_err));
        if (!pin_err) begin
            checkOutput("model_addr", 64'(first.addr), 64'(pin_addr));
            checkOutput("model_be", 64'(first.be), 64'(pin_be));
            checkOutput("model_data", 64'(first.data), 64'(pin_data));
        end
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        if (stall > 0) begin
            fork
                begin
                    repeat (stall) @(posedge clk);
                    #1 mem_ready = 1'b1;
                end
            join_none
        end
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (k == 0) checkOutput("req_ready_drop", 64'(req_ready), 64'd0);
            if (k < stall) checkOutput("stall_hold_valid", 64'(mem_valid), 64'd1);
            if (done) begin
                seen = 1'b1;
                checkOutput("done_latency", 64'(cyc - acc + 1), 64'(exp_lat));
            end
            k++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done, expected done at N+%0d", exp_lat);
        end else begin
            @(negedge clk);
            checkOutput("done_one_cycle", 64'(done), 64'd0);
            checkOutput("ready_after_resp", 64'(req_ready), 64'd1);
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        na_req_valid = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_size     = 2'b00;
        mem_ready    = 1'b1;
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h0000_1003, 32'hDEAD_BEEF, 2'b00, 0, 2, 1'b0, 32'h0000_1000, 4'b1000, 32'hEF00_0000);
        applyStimulus(32'h0000_2002, 32'h0000_ABCD, 2'b01, 0, 2, 1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_0000);
        applyStimulus(32'h0000_3001, 32'h1122_3344, 2'b10, 0, 3, 1'b0, 32'h0000_3000, 4'b1110, 32'h2233_4400);
        applyStimulus(32'h0000_4000, 32'hCAFE_F00D, 2'b10, 3, 5, 1'b0, 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
        applyStimulus(32'h0000_6000, 32'h1234_5678, 2'b11, 0, 1, 1'b1, 32'h0, 4'b0000, 32'h0);
        applyStimulus(32'h0000_5003, 32'h5555_BEEF, 2'b01, 0, 3, 1'b0, 32'h0000_5000, 4'b1000, 32'hEF00_0000);
        applyStimulus(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'b10, 1, 4, 1'b0, 32'hFFFF_FFFC, 4'b1100, 32'hC3D4_0000);

        // Misaligned halfword on the instance that rejects boundary crossings.
        @(negedge clk);
        req_addr     = 32'h0000_5003;
        req_wdata    = 32'h0000_BEEF;
        req_size     = 2'b01;
        na_req_valid = 1'b1;
        @(posedge clk);
        #1 na_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("na_reject_valid", 64'(na_mem_valid), 64'd0);
        checkOutput("na_reject_done", 64'(na_done), 64'd1);
        checkOutput("na_reject_err", 64'(na_err), 64'd1);
        @(negedge clk);
        checkOutput("na_reject_done_clear", 64'(na_done), 64'd0);
        checkOutput("na_reject_ready", 64'(na_req_ready), 64'd1);
        req_addr     = 32'h0000_5002;
        na_req_valid = 1'b1;
        @(posedge clk);
        #1 na_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("na_aligned_valid", 64'(na_mem_valid), 64'd1);
        checkOutput("na_aligned_be", 64'(na_mem_be), 64'b1100);
        checkOutput("na_aligned_wdata", 64'(na_mem_wdata), 64'hBEEF_0000);
        @(negedge clk);
        checkOutput("na_aligned_done", 64'(na_done), 64'd1);
        checkOutput("na_aligned_err", 64'(na_err), 64'd0);

        // Reset during the second beat of a split store.
        waitReady();
        mem_ready = 1'b1;
        req_addr  = 32'h0000_3001;
        req_wdata = 32'h1122_3344;
        req_size  = 2'b10;
        begin
            bit    m_err;
            int    nbeats;
            beat_t first;
            modelPush(32'h0000_3001, 32'h1122_3344, 2'b10, m_err, nbeats, first);
            checkOutput("model_split_beats", 64'(nbeats), 64'd2);
        end
        exp_err   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("pre_reset_beat1_addr", 64'(mem_addr), 64'h0000_3004);
        checkOutput("pre_reset_beat1_be", 64'(mem_be), 64'b0001);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_done_after_reset", 64'(done), 64'd0);
        end
        applyStimulus(32'h0000_7004, 32'h0BAD_F00D, 2'b10, 0, 2, 1'b0, 32'h0000_7004, 4'b1111, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-path counterpart to the immediate/load sign-extender. Takes a 32-bit register value plus byte address and access size (SB/SH/SW) from the execute stage.
- Narrows and aligns the value onto the 32-bit data-memory write port, generating byte enables.
- Splits misaligned halfword/word stores that cross a word boundary into two bus beats, using a valid/ready handshake on both sides.

Parameters:
- ADDR_W, 32, byte-address width.
- ALLOW_MISALIGNED, 1. When 1, boundary-crossing stores are split into two beats. When 0, they are rejected with err and no bus traffic.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  rs2 value; only low 8/16 bits are used for SB/SH.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- mem_valid  out  1  bus beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables, bit i = byte lane i.
- done  out  1  one-cycle pulse: request finished.
- err  out  1  one-cycle pulse coincident with done: request rejected.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, err=0. Asserting reset mid-transaction aborts it; no done is issued.
- Accept: on req_valid&&req_ready at edge N, register addr, wdata and size. req_ready drops at N+1.
- Lane math, with off=req_addr[1:0]:
  - mask8 = 0x01 / 0x03 / 0x0F for byte / half / word.
  - be8 = mask8<<off.
  - d64 = zero-extended sized data << (8*off).
  - beat0: addr=req_addr&~3, be=be8[3:0], data=d64[31:0].
  - beat1: addr=beat0 addr+4 (wraps modulo 2^ADDR_W), be=be8[7:4], data=d64[63:32].
  - split = (be8[7:4]!=0).
- Error cases: size=11, or split with ALLOW_MISALIGNED=0.
  - Transition IDLE->RESP. No mem_valid is asserted.
  - done=1 and err=1 for one cycle at N+1.
- States:
  - IDLE: req_ready=1. On accept, go to BEAT0, or to RESP on error.
  - BEAT0: mem_valid=1 from N+1. Outputs hold stable until mem_ready. On handshake, go to BEAT1 if split, else RESP.
  - BEAT1: mem_valid=1, second-beat fields. On handshake, go to RESP.
  - RESP: done=1 (err as computed) for exactly one cycle, then IDLE.
- Latency: aligned store with mem_ready tied high has mem_valid at N+1, done at N+2, next accept at N+3.
- mem_valid never drops without a handshake. Fields are stable while mem_valid&&!mem_ready.
- mem_valid is 0 in IDLE and RESP. mem_wdata lanes with be=0 are driven 0.
- req_valid is ignored while req_ready=0. There are no simultaneous accept/complete cycles.

Decomposition:
- Shared package (riscv_pkg): SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings, state enum (IDLE, BEAT0, BEAT1, RESP).
- Sub-module store_lane_align: combinational, computes be8, d64 and split from (off, size, wdata). It is reusable by the load-side extractor.

Test Plan:
- SB addr=0x1003, wdata=0xDEADBEEF, mem_ready=1 -> one beat: addr=0x1000, be=1000, wdata=0xEF000000; done at N+2, err=0.
- SH addr=0x2002, wdata=0x0000ABCD -> one beat: addr=0x2000, be=1100, wdata=0xABCD0000.
- SW addr=0x3001, wdata=0x11223344, ALLOW_MISALIGNED=1 -> beat0 addr=0x3000 be=1110 wdata=0x22334400; beat1 addr=0x3004 be=0001 wdata=0x00000011; one done.
- SW aligned addr=0x4000 with mem_ready low for 3 cycles -> mem_valid and all fields held stable 3 cycles; done the cycle after the handshake.
- req_size=11, and separately SH addr=0x5003 with ALLOW_MISALIGNED=0 -> no mem_valid; done=err=1 at N+1.
- rst_n pulsed low during BEAT1 of a split store -> all outputs immediately at reset values, no done; next request processed normally.
